// File: rtl/ulight_fifo_timecode_tx_ctrl.sv
// Avalon-MM time-code transmit controller: CPU and periodic auto-generator
// feed a first-word-fall-through FIFO that drives the link tick/time inputs
// over a valid/ready handshake. Status, sticky overflow and a level IRQ are
// exposed through a four-register map.
module ulight_fifo_timecode_tx_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic                  tc_valid,
    output logic [DATA_WIDTH-1:0] tc_data,
    input  logic                  tc_ready,
    output logic                  irq
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]           DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [PERIOD_WIDTH-1:0] PERIOD_ONE = PERIOD_WIDTH'(1);

    typedef enum logic {
        IDLE,
        AUTO
    } state_t;

    // FIFO storage and pointers
    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [CW-1:0]           count;

    // Control / status registers
    logic                    enable;
    logic                    irq_en;
    logic [1:0]              flags;
    logic [PERIOD_WIDTH-1:0] period;
    logic [DATA_WIDTH-1:0]   last_sent;
    logic                    overflow;

    // Auto generator
    state_t                  state;
    logic [PERIOD_WIDTH-1:0] counter;
    logic [5:0]              auto_time;

    // Decoded strobes and datapath
    logic                    wr_en;
    logic                    wr_data_reg;
    logic                    wr_ctrl;
    logic                    wr_status;
    logic                    wr_period;
    logic                    flush;
    logic                    empty;
    logic                    full;
    logic                    pop;
    logic                    auto_fire;
    logic [DATA_WIDTH-1:0]   auto_code;
    logic                    push_req;
    logic [DATA_WIDTH-1:0]   push_data;
    logic                    push_ok;
    logic                    ovf_set;
    logic                    unused_bits;

    assign wr_en       = chipselect && !write_n;
    assign wr_data_reg = wr_en && (address == 2'd0);
    assign wr_ctrl     = wr_en && (address == 2'd1);
    assign wr_status   = wr_en && (address == 2'd2);
    assign wr_period   = wr_en && (address == 2'd3);
    assign flush       = wr_ctrl && writedata[3];

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    assign tc_valid = enable && !empty;
    assign tc_data  = empty ? '0 : mem[rd_ptr];
    assign pop      = tc_valid && tc_ready;

    // A period of 0 or 1 fires every cycle; otherwise fire on the last count.
    assign auto_fire = (state == AUTO) &&
                       ((period <= PERIOD_ONE) || (counter >= period - PERIOD_ONE));
    assign auto_code = DATA_WIDTH'({flags, auto_time});

    // CPU write has priority over a coincident auto push; the loser counts as overflow.
    assign push_req  = wr_data_reg || auto_fire;
    assign push_data = wr_data_reg ? writedata[DATA_WIDTH-1:0] : auto_code;
    assign push_ok   = push_req && !flush && (!full || pop);
    assign ovf_set   = (push_req && !flush && full && !pop) ||
                       (auto_fire && wr_data_reg);

    assign unused_bits = &{1'b0, writedata};

    // Register read mux, zero-extended
    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata = 32'(last_sent);
            2'd1:    readdata = {24'b0, flags, 3'b000, irq_en, (state == AUTO), enable};
            2'd2:    readdata = {16'b0, 8'(count), 5'b0, overflow, full, empty};
            default: readdata = 32'(period);
        endcase
    end

    // FIFO storage, pointers and occupancy count; flush overrides any push
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Capture the code handed to the link on each completed handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_sent <= '0;
        end else if (pop) begin
            last_sent <= tc_data;
        end
    end

    // Sticky overflow (set beats write-1-to-clear) and registered interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (wr_status && writedata[2]) begin
                overflow <= 1'b0;
            end
            irq <= overflow && irq_en;
        end
    end

    // CTRL and PERIOD registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable <= 1'b0;
            irq_en <= 1'b0;
            flags  <= 2'b00;
            period <= '0;
        end else begin
            if (wr_ctrl) begin
                enable <= writedata[0];
                irq_en <= writedata[2];
                flags  <= writedata[7:6];
            end
            if (wr_period) begin
                period <= writedata[PERIOD_WIDTH-1:0];
            end
        end
    end

    // Auto-mode state machine: period counter and wrapping 6-bit time value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            counter   <= '0;
            auto_time <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_ctrl && writedata[1]) begin
                        state   <= AUTO;
                        counter <= '0;
                    end
                end
                AUTO: begin
                    if (wr_ctrl && !writedata[1]) begin
                        state <= IDLE;
                    end
                    if (auto_fire) begin
                        counter   <= '0;
                        auto_time <= auto_time + 6'd1;
                    end else begin
                        counter <= counter + PERIOD_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ulight_fifo_timecode_tx_ctrl.sv
// Directed bench for ulight_fifo_timecode_tx_ctrl with a scoreboard of
// expected link codes checked at every valid/ready handshake.
module tb_ulight_fifo_timecode_tx_ctrl;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        tc_valid;
    logic [7:0]  tc_data;
    logic        tc_ready;
    logic        irq;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    int last_hs = -1;
    logic spacing_on = 1'b0;
    logic [7:0] exp_q [$];

    ulight_fifo_timecode_tx_ctrl #(
        .DATA_WIDTH  (8),
        .FIFO_DEPTH  (4),
        .PERIOD_WIDTH(16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .tc_valid  (tc_valid),
        .tc_data   (tc_data),
        .tc_ready  (tc_ready),
        .irq       (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd_check(input logic [1:0] a, input logic [31:0] exp, input string tag);
        @(posedge clk); #1;
        address = a;
        #2;
        check(tag, readdata, exp);
    endtask

    task automatic wait_drain(input int max_cycles, input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Handshake monitor: sampled mid-cycle, the transfer completes at the next edge
    always @(negedge clk) begin
        logic [7:0] e;
        cycle++;
        if (!spacing_on) last_hs = -1;
        if (reset_n && tc_valid && tc_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_code", 32'(tc_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("tc_data", 32'(tc_data), 32'(e));
            end
            if (spacing_on) begin
                if (last_hs >= 0) check("auto_spacing", 32'(cycle - last_hs), 32'd10);
                last_hs = cycle;
            end
        end
    end

    initial begin
        chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = '0;
        tc_ready = 1'b0; reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        check("rst_tc_valid", 32'(tc_valid), 32'd0);
        check("rst_tc_data", 32'(tc_data), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        rd_check(2'd0, 32'h0, "rst_data");
        rd_check(2'd1, 32'h0, "rst_ctrl");
        rd_check(2'd2, 32'h0001, "rst_status");
        rd_check(2'd3, 32'h0, "rst_period");

        // Single code, one-cycle latency
        tc_ready = 1'b1;
        wr(2'd1, 32'h1);
        exp_q.push_back(8'h15);
        wr(2'd0, 32'h15);
        check("lat_tc_valid", 32'(tc_valid), 32'd1);
        check("lat_tc_data", 32'(tc_data), 32'h15);
        rd_check(2'd0, 32'h15, "last_sent");
        rd_check(2'd2, 32'h0001, "status_after_send");

        // Overfill with link stalled
        tc_ready = 1'b0;
        wr(2'd1, 32'h5);
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            wr(2'd0, 32'(i));
        end
        check("full_head_valid", 32'(tc_valid), 32'd1);
        check("full_head_data", 32'(tc_data), 32'h01);
        rd_check(2'd2, 32'h0406, "status_full_ovf");
        check("irq_set", 32'(irq), 32'd1);
        tc_ready = 1'b1;
        wait_drain(20, "drain_overfill");
        wr(2'd2, 32'h4);
        rd_check(2'd2, 32'h0001, "status_w1c");
        @(posedge clk); #1;
        check("irq_clear", 32'(irq), 32'd0);

        // Full FIFO: simultaneous pop and push
        tc_ready = 1'b0;
        for (int i = 8'h21; i <= 8'h24; i++) begin
            exp_q.push_back(8'(i));
            wr(2'd0, 32'(i));
        end
        exp_q.push_back(8'h25);
        @(posedge clk); #1;
        tc_ready = 1'b1;
        chipselect = 1'b1; write_n = 1'b0; address = 2'd0; writedata = 32'h25;
        @(posedge clk); #1;
        tc_ready = 1'b0;
        chipselect = 1'b0; write_n = 1'b1;
        rd_check(2'd2, 32'h0402, "status_push_pop_full");
        tc_ready = 1'b1;
        wait_drain(20, "drain_push_pop");

        // Auto mode: period 10, flags 01, 65 codes to cover the 63->0 wrap
        wr(2'd3, 32'd10);
        rd_check(2'd3, 32'd10, "period_rb");
        for (int i = 0; i < 65; i++) exp_q.push_back(8'h40 | 8'(i % 64));
        spacing_on = 1'b1;
        wr(2'd1, 32'h43);
        rd_check(2'd1, 32'h43, "ctrl_rb_auto");
        wait_drain(800, "drain_auto");
        spacing_on = 1'b0;
        wr(2'd1, 32'h1);
        rd_check(2'd1, 32'h1, "ctrl_rb_idle");

        // Disabled queue, then flush
        wr(2'd1, 32'h0);
        for (int i = 8'h31; i <= 8'h33; i++) wr(2'd0, 32'(i));
        check("disabled_tc_valid", 32'(tc_valid), 32'd0);
        rd_check(2'd2, 32'h0300, "status_disabled");
        wr(2'd1, 32'h8);
        rd_check(2'd2, 32'h0001, "status_flush");
        wr(2'd1, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        check("flush_tc_valid", 32'(tc_valid), 32'd0);

        // Asynchronous reset during a pending transfer
        tc_ready = 1'b0;
        wr(2'd0, 32'h3A);
        check("pre_reset_valid", 32'(tc_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_valid", 32'(tc_valid), 32'd0);
        check("async_reset_data", 32'(tc_data), 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        rd_check(2'd2, 32'h0001, "post_reset_status");
        rd_check(2'd1, 32'h0, "post_reset_ctrl");
        rd_check(2'd0, 32'h0, "post_reset_data");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
